// File: rtl/cpu_pkg.sv
// Shared core definitions: load-type encoding and writeback constants.
// Imported by the MEM/WB stage and its load alignment helper.
package cpu_pkg;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LBU  = 3'd2,
        LD_LH   = 3'd3,
        LD_LHU  = 3'd4,
        LD_LW   = 3'd5
    } load_type_e;

    localparam logic [31:0] LINK_OFFSET = 32'd8;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Little-endian load formatter: picks the addressed byte/halfword,
// extends it, and flags accesses that break natural alignment.
module load_align
    import cpu_pkg::*;
(
    input  logic [31:0] i_raw,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_type,
    output logic [31:0] o_data,
    output logic        o_is_load,
    output logic        o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_raw[8*i_offset +: 8];
    assign w_half = i_offset[1] ? i_raw[31:16] : i_raw[15:0];

    always_comb begin
        o_data       = i_raw;
        o_is_load    = 1'b1;
        o_misaligned = 1'b0;
        case (i_type)
            LD_LB:  o_data = {{24{w_byte[7]}}, w_byte};
            LD_LBU: o_data = {24'd0, w_byte};
            LD_LH: begin
                o_data       = {{16{w_half[15]}}, w_half};
                o_misaligned = i_offset[0];
            end
            LD_LHU: begin
                o_data       = {16'd0, w_half};
                o_misaligned = i_offset[0];
            end
            LD_LW:  o_misaligned = (i_offset != 2'd0);
            // Codes 0, 6 and 7 are all plain non-loads.
            default: o_is_load = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects the writeback value, drives the
// register file write port and counts retired instructions.
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_valid,
    input  logic                mem_reg_write,
    input  logic [4:0]          mem_rd,
    input  logic [31:0]         mem_alu_result,
    input  logic [31:0]         mem_load_data,
    input  logic [2:0]          mem_load_type,
    input  logic                mem_link,
    input  logic [31:0]         mem_pc,
    input  logic                flush,
    output logic [4:0]          write_addr,
    output logic [31:0]         write_data,
    output logic                reg_write,
    output logic                wb_valid,
    output logic                misalign_err,
    output logic [RETIRE_W-1:0] retire_count
);

    logic [31:0]         w_ld_data;
    logic                w_is_load;
    logic                w_mis;
    logic [31:0]         w_wb_data;
    logic                w_take;

    logic [4:0]          r_write_addr;
    logic [31:0]         r_write_data;
    logic                r_reg_write;
    logic                r_wb_valid;
    logic                r_misalign;
    logic [RETIRE_W-1:0] r_retire;

    load_align u_align (
        .i_raw        (mem_load_data),
        .i_offset     (mem_alu_result[1:0]),
        .i_type       (mem_load_type),
        .o_data       (w_ld_data),
        .o_is_load    (w_is_load),
        .o_misaligned (w_mis)
    );

    assign w_take    = mem_valid & ~flush;
    assign w_wb_data = mem_link  ? mem_pc + LINK_OFFSET :
                       w_is_load ? w_ld_data : mem_alu_result;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_write_addr <= 5'd0;
            r_write_data <= 32'd0;
            r_reg_write  <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_misalign   <= 1'b0;
            r_retire     <= '0;
        end else if (w_take) begin
            r_write_addr <= mem_rd;
            r_write_data <= w_wb_data;
            r_reg_write  <= mem_reg_write & (|mem_rd) & ~w_mis;
            r_wb_valid   <= 1'b1;
            r_misalign   <= w_mis;
            r_retire     <= r_retire + RETIRE_W'(1);
        end else begin
            r_write_addr <= 5'd0;
            r_write_data <= 32'd0;
            r_reg_write  <= 1'b0;
            r_wb_valid   <= 1'b0;
            r_misalign   <= 1'b0;
        end
    end

    assign write_addr   = r_write_addr;
    assign write_data   = r_write_data;
    assign reg_write    = r_reg_write;
    assign wb_valid     = r_wb_valid;
    assign misalign_err = r_misalign;
    assign retire_count = r_retire;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed plus random checks of mem_wb_stage against a behavioural
// writeback model kept in the bench.
module tb_mem_wb_stage;

    logic        clk;
    logic        reset;
    logic        mem_valid;
    logic        mem_reg_write;
    logic [4:0]  mem_rd;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_load_data;
    logic [2:0]  mem_load_type;
    logic        mem_link;
    logic [31:0] mem_pc;
    logic        flush;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic        reg_write;
    logic        wb_valid;
    logic        misalign_err;
    logic [31:0] retire_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_retire;
    logic [31:0] e_data;
    logic [4:0]  e_addr;
    logic        e_rw, e_valid, e_mis;

    mem_wb_stage #(.RETIRE_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_valid      (mem_valid),
        .mem_reg_write  (mem_reg_write),
        .mem_rd         (mem_rd),
        .mem_alu_result (mem_alu_result),
        .mem_load_data  (mem_load_data),
        .mem_load_type  (mem_load_type),
        .mem_link       (mem_link),
        .mem_pc         (mem_pc),
        .flush          (flush),
        .write_addr     (write_addr),
        .write_data     (write_data),
        .reg_write      (reg_write),
        .wb_valid       (wb_valid),
        .misalign_err   (misalign_err),
        .retire_count   (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Expected writeback for the current inputs, from the ISA rules.
    task automatic model();
        int unsigned off, sh, hf;
        int signed   sv;
        logic [31:0] v;
        off = int'(mem_alu_result[1:0]);
        sh  = (mem_load_data >> (8 * off)) & 32'hFF;
        hf  = (mem_load_data >> (16 * (off / 2))) & 32'hFFFF;
        if (reset) begin
            {e_valid, e_rw, e_mis} = 3'b000;
            e_addr = 0; e_data = 0; m_retire = 0;
        end else if (flush || !mem_valid) begin
            {e_valid, e_rw, e_mis} = 3'b000;
            e_addr = 0; e_data = 0;
        end else begin
            e_mis = 1'b0;
            case (mem_load_type)
                3'd1: begin sv = (sh >= 128) ? int'(sh) - 256 : int'(sh); v = sv; end
                3'd2: v = sh;
                3'd3: begin
                    sv = (hf >= 32768) ? int'(hf) - 65536 : int'(hf);
                    v = sv; e_mis = (off % 2) != 0;
                end
                3'd4: begin v = hf; e_mis = (off % 2) != 0; end
                3'd5: begin v = mem_load_data; e_mis = off != 0; end
                default: v = mem_alu_result;
            endcase
            if (mem_link) v = mem_pc + 8;
            e_data  = v;
            e_addr  = mem_rd;
            e_valid = 1'b1;
            e_rw    = mem_reg_write && mem_rd != 0 && !e_mis;
            m_retire = m_retire + 1;
        end
    endtask

    task automatic tick();
        model();
        @(posedge clk);
        #1;
        chk("wb_valid", 32'(wb_valid), 32'(e_valid));
        chk("reg_write", 32'(reg_write), 32'(e_rw));
        chk("misalign", 32'(misalign_err), 32'(e_mis));
        chk("addr", 32'(write_addr), 32'(e_addr));
        if (!e_mis) chk("data", write_data, e_data);
        chk("retire", retire_count, m_retire);
        @(negedge clk);
    endtask

    task automatic set_op(input logic v, input logic rw, input logic [4:0] rd,
                          input logic [31:0] alu, input logic [31:0] ld,
                          input logic [2:0] lt, input logic lk,
                          input logic [31:0] pc);
        mem_valid = v; mem_reg_write = rw; mem_rd = rd;
        mem_alu_result = alu; mem_load_data = ld; mem_load_type = lt;
        mem_link = lk; mem_pc = pc;
    endtask

    initial begin
        m_retire = 0;
        reset = 1'b1; flush = 1'b0;
        set_op(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // ALU op to r8
        set_op(1, 1, 8, 32'h1234_5678, 0, 0, 0, 0);
        tick();
        chk("alu_data", write_data, 32'h1234_5678);
        chk("alu_cnt", retire_count, 32'd1);

        // Reset arriving with a valid op discards it
        set_op(1, 1, 9, 32'hAAAA_5555, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        chk("rst_rw", 32'(reg_write), 32'd0);
        chk("rst_cnt", retire_count, 32'd0);
        reset = 1'b0;

        set_op(1, 1, 4, 32'h0000_1002, 32'h80FF_7F01, 3'd1, 0, 0);
        tick();
        chk("lb", write_data, 32'hFFFF_FFFF);
        set_op(1, 1, 4, 32'h0000_1003, 32'h80FF_7F01, 3'd2, 0, 0);
        tick();
        chk("lbu", write_data, 32'h0000_0080);
        set_op(1, 1, 4, 32'h0000_1000, 32'h80FF_7F01, 3'd3, 0, 0);
        tick();
        chk("lh", write_data, 32'h0000_7F01);
        set_op(1, 1, 4, 32'h0000_1002, 32'h80FF_7F01, 3'd4, 0, 0);
        tick();
        chk("lhu", write_data, 32'h0000_80FF);
        set_op(1, 1, 4, 32'h0000_1000, 32'h80FF_7F01, 3'd5, 0, 0);
        tick();
        chk("lw", write_data, 32'h80FF_7F01);

        // Misaligned LW: write suppressed, pulse for one cycle
        set_op(1, 1, 5, 32'h0000_07FE, 32'h80FF_7F01, 3'd5, 0, 0);
        tick();
        chk("mis_pulse", 32'(misalign_err), 32'd1);
        chk("mis_rw", 32'(reg_write), 32'd0);
        set_op(1, 1, 6, 32'd7, 0, 0, 0, 0);
        tick();
        chk("mis_clear", 32'(misalign_err), 32'd0);

        set_op(1, 1, 31, 32'd0, 0, 0, 1, 32'h0040_0010);
        tick();
        chk("jal", write_data, 32'h0040_0018);
        set_op(1, 1, 31, 32'd0, 0, 0, 1, 32'hFFFF_FFFC);
        tick();
        chk("jal_wrap", write_data, 32'h0000_0004);
        set_op(1, 1, 0, 32'h55, 0, 0, 0, 0);
        tick();
        chk("rd0_rw", 32'(reg_write), 32'd0);
        chk("rd0_valid", 32'(wb_valid), 32'd1);

        // Flush beats a valid load
        set_op(1, 1, 3, 32'h100, 32'h1, 3'd5, 0, 0);
        flush = 1'b1;
        tick();
        chk("flush_valid", 32'(wb_valid), 32'd0);
        flush = 1'b0;

        for (int i = 0; i < 4; i++) begin
            set_op(1, 1, 5'(10 + i), 32'(i * 3), 0, 0, 0, 0);
            tick();
            chk("b2b_rw", 32'(reg_write), 32'd1);
        end

        // Undefined load types behave as non-loads
        set_op(1, 1, 7, 32'hCAFE_0001, 32'hDEAD_BEEF, 3'd6, 0, 0);
        tick();
        chk("ld6", write_data, 32'hCAFE_0001);

        for (int i = 0; i < 300; i++) begin
            set_op(($urandom_range(3) != 0), 1'($urandom), 5'($urandom),
                   $urandom, $urandom, 3'($urandom_range(7)),
                   ($urandom_range(5) == 0), $urandom);
            flush = ($urandom_range(7) == 0);
            reset = ($urandom_range(49) == 0);
            tick();
        end
        reset = 1'b0; flush = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register and writeback formatter for the five-stage MIPS-style core. Samples the memory stage's result each clock, sign/zero-extends and aligns load data, selects the writeback value (ALU result, aligned load, or link address), and drives the register file's write port (write_addr, write_data, reg_write). Also flags misaligned loads and keeps a retired-instruction counter for the debug block.

## Interface
Parameters:
- RETIRE_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- mem_valid  in  1  MEM stage presents an instruction this cycle
- mem_reg_write  in  1  instruction writes a GPR
- mem_rd  in  5  destination register
- mem_alu_result  in  32  ALU result; also the load address
- mem_load_data  in  32  raw word read from data memory
- mem_load_type  in  3  LD_NONE/LB/LBU/LH/LHU/LW
- mem_link  in  1  jal/jalr: write mem_pc+8
- mem_pc  in  32  PC of the instruction
- flush  in  1  exception flush: load a bubble
- write_addr  out  5  to register file
- write_data  out  32  to register file
- reg_write  out  1  to register file
- wb_valid  out  1  stage holds a valid instruction
- misalign_err  out  1  one-cycle pulse: misaligned load retired
- retire_count  out  RETIRE_W  valid instructions retired

## Operation
- Single register stage; all outputs come straight from flops (no combinational path input→output).
- Per-edge priority: reset > flush > load. flush or !mem_valid loads a bubble: wb_valid=0, reg_write=0, misalign_err=0; write_addr/write_data cleared to 0.
- Writeback value: mem_link → mem_pc+32'd8 (wraps mod 2^32); else load type ≠ LD_NONE → aligned load; else mem_alu_result.
- Load alignment, little-endian, offset = mem_alu_result[1:0]: LB/LBU select byte offset, sign/zero-extend; LH/LHU select halfword offset[1], sign/zero-extend; LW whole word.
- Misaligned: LH/LHU with offset[0]=1, LW with offset≠0. Write suppressed (reg_write=0), misalign_err=1 for that cycle, instruction still counts as retired.
- reg_write = mem_valid & mem_reg_write & (mem_rd≠0) & !misaligned. rd=0 never asserts reg_write.
- retire_count increments by 1 each edge at which a valid (non-flushed) instruction is loaded; wraps to 0 at all-ones.
- Undefined mem_load_type codes (6,7) treated as LD_NONE.

## Timing
- Latency 1: inputs sampled at edge N appear on outputs during cycle N+1; register file commits at edge N+2 and bypasses write_data to its read ports during N+1.
- Reset (sync): write_addr=0, write_data=0, reg_write=0, wb_valid=0, misalign_err=0, retire_count=0. Reset asserted mid-stream discards the held instruction; no write issued the following cycle.
- flush together with mem_valid=1: bubble wins, retire_count unchanged.
- Back-to-back valid instructions: one per cycle, no bubbles inserted.
- misalign_err is a pulse, high only during the cycle its instruction is in the stage.

## Structure
- Shared package cpu_pkg: load-type encoding LD_NONE=0, LD_LB=1, LD_LBU=2, LD_LH=3, LD_LHU=4, LD_LW=5; LINK_OFFSET=32'd8.
- Sub-module load_align (combinational): raw word, offset, load type → aligned 32-bit value + misaligned flag. Instantiated once before the stage register.

## Test plan
- Reset then idle: all outputs 0; assert reset mid-stream with a valid ALU op loaded → next cycle reg_write=0, retire_count=0.
- ALU op rd=8, result 0x1234_5678 → next cycle write_addr=8, write_data=0x1234_5678, reg_write=1, retire_count=1.
- Loads of word 0x80FF_7F01: LB offset 2 → 0xFFFF_FFFF; LBU offset 3 → 0x0000_0080; LH offset 0 → 0x0000_7F01; LHU offset 2 → 0x0000_80FF; LW offset 0 → 0x80FF_7F01.
- LW at address 0x0000_07FE rd=5 → reg_write=0, misalign_err=1 for one cycle, retire_count increments.
- jal rd=31, mem_pc=0x0040_0010 → write_data=0x0040_0018; mem_pc=0xFFFF_FFFC → write_data=0x0000_0004; ALU op with rd=0 → reg_write=0, wb_valid=1.
- flush asserted with valid load rd=3 → reg_write=0, wb_valid=0, retire_count unchanged; four back-to-back valid ops → four consecutive writes, retire_count+4.
